// File: rtl/mux_src_arbiter_if.sv
// Handshake bundle for the 3-source mux arbiter: source valid/data/ready
// toward the requesters, registered word with valid/ready toward downstream.
interface mux_src_arbiter_if #(
  parameter int DW = 8
);
  logic          v0, v1, v2;
  logic [DW-1:0] d0, d1, d2;
  logic          rdy0, rdy1, rdy2;
  logic [2:0]    sel;
  logic [DW-1:0] data_out;
  logic          out_valid;
  logic          out_ready;

  modport slave (
    input  v0, v1, v2, d0, d1, d2, out_ready,
    output rdy0, rdy1, rdy2, sel, data_out, out_valid
  );

  modport master (
    output v0, v1, v2, d0, d1, d2, out_ready,
    input  rdy0, rdy1, rdy2, sel, data_out, out_valid
  );
endinterface

// File: rtl/mux_src_arbiter.sv
// Round-robin arbiter with per-owner burst limit feeding a registered mux stage.
// Ports: clk, rst (sync, active high), bus (slave view of mux_src_arbiter_if).
module mux_src_arbiter #(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  mux_src_arbiter_if.slave   bus
);
  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] BMAX = CW'(BURST);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_d;
  logic [1:0]    owner;
  logic [CW-1:0] burst_cnt;
  logic [2:0]    v, rdy;
  logic [1:0]    o1, o2, grant;
  logic          can_load, others, keep, go;
  logic [DW-1:0] d_g;

  assign v        = {bus.v2, bus.v1, bus.v0};
  assign can_load = !bus.out_valid || bus.out_ready;
  assign go       = !rst && can_load && (|v);

  // Owner only gets a sticky claim once BUSY; from IDLE the search
  // starts at owner+1 so the first grant after reset goes to source 0.
  always_comb begin
    o1     = (owner == 2'd2) ? 2'd0 : owner + 2'd1;
    o2     = (o1 == 2'd2) ? 2'd0 : o1 + 2'd1;
    others = |(v & ~(3'b001 << owner));
    keep   = (state == BUSY) && v[owner] &&
             ((burst_cnt < BMAX) || !others);
    grant  = owner;
    if (keep)       grant = owner;
    else if (v[o1]) grant = o1;
    else if (v[o2]) grant = o2;
    rdy    = go ? (3'b001 << grant) : 3'b000;
  end

  assign bus.rdy0 = rdy[0];
  assign bus.rdy1 = rdy[1];
  assign bus.rdy2 = rdy[2];

  always_comb begin
    d_g = bus.d0;
    unique case (grant)
      2'd1:    d_g = bus.d1;
      2'd2:    d_g = bus.d2;
      default: d_g = bus.d0;
    endcase
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (go) state_d = BUSY;
      BUSY: if (!bus.out_valid && !(|v)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.data_out  <= '0;
      bus.out_valid <= 1'b0;
      bus.sel       <= 3'b000;
      owner         <= 2'd2;
      burst_cnt     <= '0;
    end else if (go) begin
      bus.data_out  <= d_g;
      bus.sel       <= {1'b0, grant};
      bus.out_valid <= 1'b1;
      if (state == IDLE || grant != owner) begin
        owner     <= grant;
        burst_cnt <= CW'(1);
      end else if (burst_cnt < BMAX) begin
        burst_cnt <= burst_cnt + CW'(1);
      end else begin
        // sole requester kept past the limit: start a fresh burst
        burst_cnt <= CW'(1);
      end
    end else begin
      if (can_load) bus.out_valid <= 1'b0;
      if (state == BUSY && state_d == IDLE) burst_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_mux_src_arbiter.sv
// Directed bench for mux_src_arbiter with BURST=4.
// Drives the interface directly and checks with immediate assertions.
module tb_mux_src_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mux_src_arbiter_if #(.DW(8)) bus ();

  mux_src_arbiter #(.DW(8), .BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rdys();
    return {29'd0, bus.rdy2, bus.rdy1, bus.rdy0};
  endfunction

  task automatic idle_srcs();
    bus.v0 = 1'b0; bus.v1 = 1'b0; bus.v2 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_srcs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  int exp_sel[13];

  initial begin
    exp_sel = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};
    bus.d0 = 8'hAA; bus.d1 = 8'h55; bus.d2 = 8'hFF;
    bus.out_ready = 1'b1;
    idle_srcs();

    // reset: rdy forced low even with a requester present
    rst = 1'b1;
    bus.v0 = 1'b1;
    tick(); tick(); tick();
    chk("rdy_in_rst", rdys(), 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_data", 32'(bus.data_out), 32'h00);
    chk("rst_sel", 32'(bus.sel), 32'h0);
    bus.v0 = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", rdys(), 32'h0);

    // single transfer from source 1
    bus.v1 = 1'b1;
    #1;
    chk("t2_rdy", rdys(), 32'h2);
    tick();
    bus.v1 = 1'b0;
    chk("t2_data", 32'(bus.data_out), 32'h55);
    chk("t2_sel", 32'(bus.sel), 32'h1);
    chk("t2_valid", 32'(bus.out_valid), 32'h1);

    // all three requesting: bursts of 4 rotate 0,1,2,0
    do_reset();
    bus.v0 = 1'b1; bus.v1 = 1'b1; bus.v2 = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      chk($sformatf("t3_sel%0d", i), 32'(bus.sel), 32'(exp_sel[i]));
    end
    idle_srcs();

    // stall holds the word, then the next grant proceeds once
    do_reset();
    bus.v0 = 1'b1;
    tick();
    bus.v0 = 1'b0;
    bus.v1 = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("t4_rdy%0d", i), rdys(), 32'h0);
      chk($sformatf("t4_data%0d", i), 32'(bus.data_out), 32'hAA);
      tick();
    end
    chk("t4_valid_held", 32'(bus.out_valid), 32'h1);
    bus.out_ready = 1'b1;
    #1;
    chk("t4_rdy_resume", rdys(), 32'h2);
    tick();
    bus.v1 = 1'b0;
    chk("t4_data_next", 32'(bus.data_out), 32'h55);
    chk("t4_sel_next", 32'(bus.sel), 32'h1);
    tick();
    chk("t4_drain", 32'(bus.out_valid), 32'h0);
    chk("t4_data_hold", 32'(bus.data_out), 32'h55);

    // owner drops mid-burst: rotate with no bubble
    do_reset();
    bus.v0 = 1'b1;
    tick();
    tick();
    bus.v0 = 1'b0;
    bus.v1 = 1'b1;
    #1;
    chk("t5_rdy", rdys(), 32'h2);
    tick();
    chk("t5_sel", 32'(bus.sel), 32'h1);
    chk("t5_data", 32'(bus.data_out), 32'h55);
    idle_srcs();

    // lone source streams past the burst limit, then reset mid-stream
    do_reset();
    bus.v2 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("t6_rdy%0d", i), rdys(), 32'h4);
      tick();
      chk($sformatf("t6_sel%0d", i), 32'(bus.sel), 32'h2);
      chk($sformatf("t6_val%0d", i), 32'(bus.out_valid), 32'h1);
    end
    rst = 1'b1;
    #1;
    chk("t6_rdy_rst", rdys(), 32'h0);
    tick();
    chk("t6_valid_rst", 32'(bus.out_valid), 32'h0);
    chk("t6_sel_rst", 32'(bus.sel), 32'h0);
    rst = 1'b0;
    bus.v0 = 1'b1;
    #1;
    chk("t6_first_rdy", rdys(), 32'h1);
    tick();
    chk("t6_first_sel", 32'(bus.sel), 32'h0);
    chk("t6_first_data", 32'(bus.data_out), 32'hAA);
    idle_srcs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
